rob_cmd_issuer: RTL and testbench

- Downstream consumer of the reorder processor's row-grouped item stream.
- On a row request from the scheduler, it issues the ROB row read and collects the item burst into a local FIFO.
- It then drives the DRAM command bus for that row: ACT, then all column RD/WR commands for the row, then PRE.
- All DRAM timing is enforced with internal counters, so one row is drained per activation.

---
 rtl/rob_cmd_issuer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_rob_cmd_issuer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_cmd_issuer.sv
// Row drain engine: fetches one ROB row into a local item FIFO, then walks it out
// on the DRAM command bus as ACT / column bursts / PRE under internal timing counters.
module rob_cmd_issuer #(
  parameter int ROW_W      = 11,
  parameter int COL_W      = 8,
  parameter int ITEM_W     = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int T_RCD      = 3,
  parameter int T_CCD      = 2,
  parameter int T_RTP      = 2,
  parameter int T_WR       = 4,
  parameter int T_RAS      = 6,
  parameter int T_RP       = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iRowReq,
  input  logic [ROW_W-1:0]  iRowAddr,
  output logic              oReqReady,
  output logic              oROB_Rd,
  output logic [ROW_W-1:0]  oROB_Row,
  input  logic              iROB_ItemValid,
  input  logic [ITEM_W-1:0] iROB_Item,
  input  logic              iROB_ItemEnd,
  output logic              oCmdValid,
  output logic [2:0]        oCmd,
  output logic [ROW_W-1:0]  oCmdRow,
  output logic [COL_W-1:0]  oCmdCol,
  output logic              oRowDone,
  output logic              oRowErr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FLD_W = COL_W + 3;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_COLLECT, S_ACT, S_RCD, S_COL, S_CCD, S_WAITPRE, S_PRE, S_RP
  } state_t;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2, CMD_WR = 3'd3, CMD_PRE = 3'd4
  } cmd_t;

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         ras_q, ras_d;
  logic [1:0]         beat_q, beat_d;
  logic               ovf_q, ovf_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [FLD_W-1:0]   mem_q [FIFO_DEPTH];

  logic               ready_q, ready_d;
  logic               rob_rd_q, rob_rd_d;
  logic [ROW_W-1:0]   rob_row_q, rob_row_d;
  logic               cmd_valid_q, cmd_valid_d;
  cmd_t               cmd_q, cmd_d;
  logic [ROW_W-1:0]   cmd_row_q, cmd_row_d;
  logic [COL_W-1:0]   cmd_col_q, cmd_col_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               push, push_ok, pop, flush, full;
  logic [FLD_W-1:0]   hd, nx;
  logic               unused_item_bits;

  assign unused_item_bits = ^iROB_Item[ITEM_W-1:COL_W+4];
  assign full = (count_q == CNT_W'(FIFO_DEPTH));
  assign hd   = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    ras_d    = (ras_q == 8'hFF) ? ras_q : ras_q + 8'd1;
    beat_d   = beat_q;
    ovf_d    = ovf_q;
    push     = 1'b0;
    push_ok  = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iRowReq) begin
          row_d   = iRowAddr;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_COLLECT;
        cnt_d   = '0;
      end
      S_COLLECT: begin
        push    = iROB_ItemValid & iROB_Item[0];
        push_ok = push & ~full;
        if (push & full) ovf_d = 1'b1;
        if (iROB_ItemEnd) begin
          if ((count_q != '0) || push_ok) begin
            state_d = S_ACT;
            ras_d   = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = ovf_q;
            ovf_d   = 1'b0;
          end
        end else if (cnt_q == 8'd15) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          ovf_d   = 1'b0;
          flush   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ACT: begin
        if (T_RCD > 1) begin
          state_d = S_RCD;
          cnt_d   = 8'(T_RCD - 2);
        end else begin
          state_d = S_COL;
        end
      end
      S_RCD: begin
        if (cnt_q == '0) state_d = S_COL;
        else             cnt_d   = cnt_q - 8'd1;
      end
      S_COL: begin
        // The head is popped on its final beat; the row closes once that was the last item.
        if (beat_q == hd[COL_W+2:COL_W+1]) begin
          pop    = 1'b1;
          beat_d = '0;
        end else begin
          beat_d = beat_q + 2'd1;
        end
        if (pop && (count_q == CNT_W'(1))) begin
          state_d = S_WAITPRE;
          cnt_d   = hd[COL_W] ? 8'(T_WR - 2) : 8'(T_RTP - 2);
        end else if (T_CCD > 1) begin
          state_d = S_CCD;
          cnt_d   = 8'(T_CCD - 2);
        end else begin
          state_d = S_COL;
        end
      end
      S_CCD: begin
        if (cnt_q == '0) state_d = S_COL;
        else             cnt_d   = cnt_q - 8'd1;
      end
      S_WAITPRE: begin
        if ((cnt_q == '0) && (ras_q >= 8'(T_RAS - 1))) state_d = S_PRE;
        else if (cnt_q != '0)                           cnt_d   = cnt_q - 8'd1;
      end
      S_PRE: begin
        if (T_RP > 1) begin
          state_d = S_RP;
          cnt_d   = 8'(T_RP - 2);
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = ovf_q;
          ovf_d   = 1'b0;
        end
      end
      S_RP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = ovf_q;
          ovf_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        count_d  = count_q - CNT_W'(1);
      end
    end

    // Outputs are decoded from the next state so the registered bus lines up with state_q.
    nx          = mem_q[rd_ptr_d];
    ready_d     = (state_d == S_IDLE);
    rob_rd_d    = (state_d == S_FETCH);
    rob_row_d   = (state_d == S_FETCH) ? row_d : '0;
    cmd_d       = CMD_NOP;
    cmd_row_d   = '0;
    cmd_col_d   = '0;
    case (state_d)
      S_ACT: begin
        cmd_d     = CMD_ACT;
        cmd_row_d = row_d;
      end
      S_PRE: begin
        cmd_d     = CMD_PRE;
        cmd_row_d = row_d;
      end
      S_COL: begin
        cmd_d     = nx[COL_W] ? CMD_WR : CMD_RD;
        cmd_col_d = nx[COL_W-1:0] + COL_W'(beat_d);
      end
      default: ;
    endcase
    cmd_valid_d = (cmd_d != CMD_NOP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      cnt_q       <= '0;
      ras_q       <= '0;
      beat_q      <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      rob_rd_q    <= 1'b0;
      rob_row_q   <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      ras_q       <= ras_d;
      beat_q      <= beat_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      rob_rd_q    <= rob_rd_d;
      rob_row_q   <= rob_row_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= iROB_Item[COL_W+3:1];
  end

  assign oReqReady = ready_q;
  assign oROB_Rd   = rob_rd_q;
  assign oROB_Row  = rob_row_q;
  assign oCmdValid = cmd_valid_q;
  assign oCmd      = cmd_q;
  assign oCmdRow   = cmd_row_q;
  assign oCmdCol   = cmd_col_q;
  assign oRowDone  = done_q;
  assign oRowErr   = err_q;

endmodule

// File: tb/tb_rob_cmd_issuer.sv
// Directed bench for rob_cmd_issuer: drains hand-built rows and compares the command
// stream, relative to the ACT cycle, against hand-computed timing.
module tb_rob_cmd_issuer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iRowReq;
  logic [10:0] iRowAddr;
  logic        oReqReady;
  logic        oROB_Rd;
  logic [10:0] oROB_Row;
  logic        iROB_ItemValid;
  logic [23:0] iROB_Item;
  logic        iROB_ItemEnd;
  logic        oCmdValid;
  logic [2:0]  oCmd;
  logic [10:0] oCmdRow;
  logic [7:0]  oCmdCol;
  logic        oRowDone;
  logic        oRowErr;

  int tests = 0;
  int fails = 0;

  logic [31:0] cap [16];
  logic [31:0] exp_q [$];
  int          cap_n, done_c, vio, rds, bad, n;
  logic        done_e, done_r;

  always #5 clk = ~clk;

  rob_cmd_issuer #(.ROW_W(11), .COL_W(8), .ITEM_W(24), .FIFO_DEPTH(8)) dut (
    .clk(clk), .resetn(resetn),
    .iRowReq(iRowReq), .iRowAddr(iRowAddr), .oReqReady(oReqReady),
    .oROB_Rd(oROB_Rd), .oROB_Row(oROB_Row),
    .iROB_ItemValid(iROB_ItemValid), .iROB_Item(iROB_Item), .iROB_ItemEnd(iROB_ItemEnd),
    .oCmdValid(oCmdValid), .oCmd(oCmd), .oCmdRow(oCmdRow), .oCmdCol(oCmdCol),
    .oRowDone(oRowDone), .oRowErr(oRowErr)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pk(input int cyc, input int cmd, input int row, input int col);
    return {8'(cyc), 4'(cmd), 12'(row), 8'(col)};
  endfunction

  function automatic logic [23:0] itm(input int col, input int los, input int size);
    return {12'd0, 2'(size), 1'(los), 8'(col), 1'b1};
  endfunction

  task automatic start_row(input string tag, input logic [10:0] row, input bit hold);
    iRowReq  = 1'b1;
    iRowAddr = row;
    tick();
    chk({tag, " rob_rd"}, 32'(oROB_Rd), 32'd1);
    chk({tag, " rob_row"}, 32'(oROB_Row), 32'(row));
    chk({tag, " ready_low"}, 32'(oReqReady), 32'd0);
    if (hold) iRowAddr = 11'h7FF;
    else      iRowReq  = 1'b0;
    tick();
  endtask

  task automatic send_item(input logic [23:0] item, input bit last);
    iROB_ItemValid = 1'b1;
    iROB_Item      = item;
    iROB_ItemEnd   = last;
    tick();
    iROB_ItemValid = 1'b0;
    iROB_Item      = '0;
    iROB_ItemEnd   = 1'b0;
  endtask

  task automatic capture;
    cap_n  = 0;
    done_c = -1;
    done_e = 1'b0;
    done_r = 1'b0;
    vio    = 0;
    rds    = 0;
    for (int i = 0; i < 16; i++) cap[i] = '1;
    for (int c = 0; c < 60; c++) begin
      if (oCmdValid !== (oCmd != 3'd0)) vio++;
      if (!oCmdValid && (oCmdRow != '0 || oCmdCol != '0)) vio++;
      if (oROB_Rd) rds++;
      if (oCmdValid && cap_n < 16) begin
        cap[cap_n] = pk(c, oCmd, oCmdRow, oCmdCol);
        cap_n++;
      end
      if (oRowDone) begin
        done_c = c;
        done_e = oRowErr;
        done_r = oReqReady;
        break;
      end
      tick();
    end
  endtask

  task automatic check_row(input string tag, input int dc, input logic de);
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s cmd%0d", tag, i), cap[i], exp_q[i]);
    chk({tag, " ncmd"}, 32'(cap_n), 32'(exp_q.size()));
    chk({tag, " done_cyc"}, 32'(done_c), 32'(dc));
    chk({tag, " err"}, 32'(done_e), 32'(de));
    chk({tag, " ready_at_done"}, 32'(done_r), 32'd1);
    chk({tag, " idle_bus"}, 32'(vio), 32'd0);
    chk({tag, " no_extra_rd"}, 32'(rds), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    iRowReq = 1'b0; iRowAddr = '0;
    iROB_ItemValid = 1'b0; iROB_Item = '0; iROB_ItemEnd = 1'b0;

    // 1: reset and idle
    repeat (3) tick();
    chk("rst ready", 32'(oReqReady), 32'd1);
    chk("rst cmd", 32'({oCmdValid, oCmd}), 32'd0);
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (oCmdValid || oCmd != 0 || oROB_Rd || oRowDone || oRowErr ||
          oCmdRow != 0 || oCmdCol != 0 || oROB_Row != 0 || !oReqReady) bad++;
    end
    chk("idle outputs", 32'(bad), 32'd0);

    // 2: single read, PRE bounded by tRAS
    start_row("r05a", 11'h05A, 1'b0);
    send_item(itm(8'h10, 0, 0), 1'b1);
    capture();
    exp_q = '{pk(0, 1, 11'h05A, 0), pk(3, 2, 0, 8'h10), pk(6, 4, 11'h05A, 0)};
    check_row("r05a", 9, 1'b0);

    // 3: WR burst then RD, request held high while busy
    start_row("r3ff", 11'h3FF, 1'b1);
    send_item(itm(8'hFE, 1, 1), 1'b0);
    send_item(itm(8'h20, 0, 0), 1'b1);
    capture();
    iRowReq = 1'b0;
    exp_q = '{pk(0, 1, 11'h3FF, 0), pk(3, 3, 0, 8'hFE), pk(5, 3, 0, 8'hFF),
              pk(7, 2, 0, 8'h20), pk(9, 4, 11'h3FF, 0)};
    check_row("r3ff", 12, 1'b0);

    // 4: four-beat write, PRE bounded by tWR
    start_row("r123", 11'h123, 1'b0);
    send_item(itm(8'h00, 1, 3), 1'b1);
    capture();
    exp_q = '{pk(0, 1, 11'h123, 0), pk(3, 3, 0, 0), pk(5, 3, 0, 1), pk(7, 3, 0, 2),
              pk(9, 3, 0, 3), pk(13, 4, 11'h123, 0)};
    check_row("r123", 16, 1'b0);

    // invalid item discarded; read burst wraps the column
    start_row("r2aa", 11'h2AA, 1'b0);
    send_item(itm(8'h33, 1, 2) & ~24'd1, 1'b0);
    send_item(itm(8'hFF, 0, 1), 1'b1);
    capture();
    exp_q = '{pk(0, 1, 11'h2AA, 0), pk(3, 2, 0, 8'hFF), pk(5, 2, 0, 8'h00),
              pk(7, 4, 11'h2AA, 0)};
    check_row("r2aa", 10, 1'b0);

    // overflow: ninth item dropped, error reported with done
    start_row("r0f0", 11'h0F0, 1'b0);
    for (int i = 0; i < 9; i++) send_item(itm(i, 0, 0), (i == 8));
    capture();
    exp_q = '{pk(0, 1, 11'h0F0, 0)};
    for (int i = 0; i < 8; i++) exp_q.push_back(pk(3 + 2 * i, 2, 0, i));
    exp_q.push_back(pk(19, 4, 11'h0F0, 0));
    check_row("r0f0", 22, 1'b1);

    // 5a: empty row
    start_row("empty", 11'h011, 1'b0);
    iROB_ItemEnd = 1'b1;
    tick();
    iROB_ItemEnd = 1'b0;
    chk("empty done", 32'(oRowDone), 32'd1);
    chk("empty err", 32'(oRowErr), 32'd0);
    chk("empty nocmd", 32'(oCmdValid), 32'd0);
    chk("empty ready", 32'(oReqReady), 32'd1);
    tick();
    chk("empty pulse", 32'(oRowDone), 32'd0);

    // 5b: collection timeout
    start_row("tmo", 11'h022, 1'b0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (oRowDone) break;
    end
    chk("tmo cycles", 32'(n), 32'd16);
    chk("tmo err", 32'(oRowErr), 32'd1);

    // 6: reset one cycle after ACT abandons the row
    start_row("r100", 11'h100, 1'b0);
    send_item(itm(8'h40, 0, 0), 1'b1);
    chk("r100 act", 32'({oCmd, oCmdRow}), 32'({3'd1, 11'h100}));
    tick();
    #1 resetn = 1'b0;
    #1;
    chk("r100 rst cmd", 32'({oCmdValid, oCmd, oCmdRow}), 32'd0);
    chk("r100 rst ready", 32'(oReqReady), 32'd1);
    tick();
    tick();
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (oCmdValid || oROB_Rd || oRowDone) bad++;
    end
    chk("r100 no_pre", 32'(bad), 32'd0);
    chk("r100 ready", 32'(oReqReady), 32'd1);

    // clean drain after reset: nothing left over in the FIFO
    start_row("post", 11'h05A, 1'b0);
    send_item(itm(8'h10, 0, 0), 1'b1);
    capture();
    exp_q = '{pk(0, 1, 11'h05A, 0), pk(3, 2, 0, 8'h10), pk(6, 4, 11'h05A, 0)};
    check_row("post", 9, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
